// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl -- single-port RAM controller serving a CPU request port and a
// sequential program-load port.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid/req_write/     CPU request (read or write) with handshake
//   req_addr/req_wdata/
//   req_ready
//   rsp_valid/rsp_rdata      one-cycle read response pulse, data held
//   prog_en/prog_valid/      program-load stream; bytes go to consecutive
//   prog_data/prog_ready/    addresses starting at 0 for each load session
//   prog_full
//   mem_addr/mem_we/mem_re/  RAM side; mem_data is a shared tristate bus
//   mem_data
//
// Transaction shapes (E0 = acceptance edge):
//   write : IDLE -E0-> WRITE -E1-> IDLE            (RAM commits at E1)
//   read  : IDLE -E0-> RD_ADDR -E1-> RD_DATA -E2-> IDLE, rsp_valid after E2
// ---------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              prog_en,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_full,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    inout  wire  [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [ADDR_W-1:0] r_prog_ptr;
    logic              r_prog_full;
    logic              r_prog_en_d;

    logic              w_idle;
    logic              w_prog_rise;
    logic [ADDR_W-1:0] w_ptr;
    logic              w_req_ready;
    logic              w_prog_ready;
    logic              w_req_go;
    logic              w_prog_go;

    assign w_idle       = (r_state == IDLE);
    assign w_prog_rise  = prog_en & ~r_prog_en_d;
    // A byte accepted in the very cycle prog_en rises must land at address 0,
    // so the pointer clear is folded in combinationally.
    assign w_ptr        = w_prog_rise ? {ADDR_W{1'b0}} : r_prog_ptr;
    assign w_req_ready  = w_idle & ~prog_en;
    assign w_prog_ready = w_idle & prog_en & ~r_prog_full;
    assign w_req_go     = req_valid & w_req_ready;
    assign w_prog_go    = prog_valid & w_prog_ready;

    // Controller FSM, program pointer/full tracking and read response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= {ADDR_W{1'b0}};
            r_data      <= {DATA_W{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_prog_ptr  <= {ADDR_W{1'b0}};
            r_prog_full <= 1'b0;
            r_prog_en_d <= 1'b0;
        end else begin
            r_prog_en_d <= prog_en;
            r_rsp_valid <= 1'b0;

            // Leaving program mode ends the load session.
            if (!prog_en) begin
                r_prog_full <= 1'b0;
            end else begin
                r_prog_full <= r_prog_full;
            end

            if (w_prog_go) begin
                r_prog_ptr <= w_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else if (w_prog_rise) begin
                r_prog_ptr <= {ADDR_W{1'b0}};
            end else begin
                r_prog_ptr <= r_prog_ptr;
            end

            case (r_state)
                IDLE: begin
                    // Only one of the two go signals can be high: ready is
                    // granted to the port selected by prog_en.
                    if (w_prog_go) begin
                        r_addr  <= w_ptr;
                        r_data  <= prog_data;
                        r_state <= WRITE;
                        if (w_ptr == {ADDR_W{1'b1}}) begin
                            r_prog_full <= 1'b1;
                        end
                    end else if (w_req_go) begin
                        r_addr  <= req_addr;
                        r_data  <= req_wdata;
                        r_state <= req_write ? WRITE : RD_ADDR;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                end
                RD_ADDR: begin
                    r_state <= RD_DATA;
                end
                RD_DATA: begin
                    r_rsp_rdata <= mem_data;
                    r_rsp_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign prog_ready = w_prog_ready;
    assign prog_full  = r_prog_full;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;

    // RAM side is decoded purely from registered state and registered
    // address/data; mem_addr keeps its last value while idle.
    assign mem_addr = r_addr;
    assign mem_we   = (r_state == WRITE);
    assign mem_re   = (r_state == RD_DATA);
    assign mem_data = (r_state == WRITE) ? r_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl -- self-checking bench for mem_ctrl. A behavioural RAM hangs
// on the tristate bus; read responses are checked through a scoreboard queue
// and a bus monitor watches the RAM-side protocol every cycle.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       prog_en, prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready, prog_full;
    logic [3:0] mem_addr;
    logic       mem_we, mem_re;
    wire  [7:0] mem_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    mem_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .prog_en(prog_en), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(prog_ready), .prog_full(prog_full),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Cycle counter used for response spacing and write timing.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: commits on mem_we, output buffer loads every edge and
    // drives the bus only while mem_re is high.
    logic [7:0] ram [16];
    logic [7:0] ram_q;
    logic       ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'hC0 + 8'(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_data;
        end
        ram_q <= ram[mem_addr];
    end
    assign mem_data = mem_re ? ram_q : 8'bzzzzzzzz;

    logic [7:0] exp_ram [16];
    logic [7:0] rsp_q[$];
    logic [3:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         wr_cyc_q[$];
    logic       prev_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus monitor and response scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        chk("we_and_re", {31'd0, mem_we & mem_re}, 32'd0);
        chk("we_pulse_len", {31'd0, mem_we & prev_we}, 32'd0);
        prev_we <= mem_we;
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
            wr_cyc_q.push_back(cyc);
        end
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, rsp_q.pop_front()});
            end
        end
    end

    // Present one CPU request and return #1 after the edge that accepts it.
    task automatic accept(input logic wr, input logic [3:0] a, input logic [7:0] d);
        bit done = 1'b0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            done = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        accept(1'b1, a, d);
        exp_ram[a] = d;
    endtask

    task automatic cpu_read(input logic [3:0] a);
        rsp_q.push_back(exp_ram[a]);
        accept(1'b0, a, 8'h00);
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && rsp_q.size() != 0; t++) @(negedge clk);
        if (rsp_q.size() != 0) begin
            chk("rsp_timeout", rsp_q.size(), 32'd0);
            rsp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Stream n program bytes base, base+1, ... with prog_valid held high.
    task automatic prog_stream(input int n, input logic [7:0] base);
        int k = 0;
        prog_valid = 1'b1;
        for (int t = 0; t < 100 && k < n; t++) begin
            bit acc;
            prog_data = base + 8'(k);
            @(negedge clk);
            acc = prog_ready;
            @(posedge clk); #1;
            if (acc) begin
                exp_ram[k[3:0]] = base + 8'(k);
                k++;
            end
        end
        if (k != n) chk("prog_timeout", k, n);
    endtask

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[10];

    initial begin
        int c1, c2;
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int c2;
        vecs[0] = '{1'b0, 4'h0, 8'h00, 8'hC0};
        vecs[1] = '{1'b1, 4'hF, 8'h5A, 8'h00};
        vecs[2] = '{1'b0, 4'hF, 8'h00, 8'h5A};
        vecs[3] = '{1'b1, 4'h0, 8'hFF, 8'h00};
        vecs[4] = '{1'b0, 4'h0, 8'h00, 8'hFF};
        vecs[5] = '{1'b0, 4'h7, 8'h00, 8'hC7};
        vecs[6] = '{1'b1, 4'h7, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 4'h7, 8'h00, 8'h00};
        vecs[8] = '{1'b0, 4'h3, 8'h00, 8'hA5};
        vecs[9] = '{1'b0, 4'hF, 8'h00, 8'h5A};
        for (int i = 0; i < 16; i++) exp_ram[i] = 8'hC0 + 8'(i);

        rst = 1'b1; ram_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_wdata = 8'h00;
        prog_en = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; ram_init = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        chk("rst_mem_we_re", {30'd0, mem_we, mem_re}, 32'd0);
        chk("rst_prog_full", {31'd0, prog_full}, 32'd0);
        chk("rst_readies", {30'd0, req_ready, prog_ready}, 32'd2);
        @(posedge clk); #1;

        // Write 0x3 <= 0xA5 with cycle-exact RAM-side checks
        cpu_write(4'h3, 8'hA5);
        @(negedge clk);
        chk("wr_e0_bus", {14'd0, mem_we, mem_re, mem_addr, mem_data, 4'd0, req_ready},
            {14'd0, 1'b1, 1'b0, 4'h3, 8'hA5, 4'd0, 1'b0});
        @(negedge clk);
        chk("wr_e1_idle", {30'd0, mem_we, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Read 0x3: RD_ADDR, RD_DATA, then response after E2
        rsp_q.push_back(8'hA5);
        accept(1'b0, 4'h3, 8'h00);
        @(negedge clk);
        chk("rd_addr_phase", {26'd0, mem_we, mem_re, mem_addr}, {26'd0, 2'b00, 4'h3});
        @(negedge clk);
        chk("rd_data_phase", {30'd0, mem_we, mem_re}, 32'd1);
        @(negedge clk);
        chk("rd_rsp_at_e2", {23'd0, rsp_valid, rsp_rdata}, {23'd0, 1'b1, 8'hA5});
        @(negedge clk);
        chk("rd_rsp_pulse_hold", {23'd0, rsp_valid, rsp_rdata}, {23'd0, 1'b0, 8'hA5});
        @(posedge clk); #1;

        // Table-driven CPU traffic
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                cpu_write(vecs[i].addr, vecs[i].data);
            end else begin
                rsp_q.push_back(vecs[i].exp);
                accept(1'b0, vecs[i].addr, 8'h00);
            end
        end
        drain();

        // Back-to-back reads, second issued in the rsp_valid cycle
        cpu_read(4'hA);
        c1 = -1;
        for (int t = 0; t < 10 && c1 < 0; t++) begin
            @(negedge clk);
            if (rsp_valid) c1 = cyc;
        end
        chk("b2b_first_rsp", {31'd0, c1 >= 0}, 32'd1);
        chk("b2b_ready_in_rsp", {31'd0, req_ready}, 32'd1);
        rsp_q.push_back(exp_ram[4'hB]);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'hB;
        @(posedge clk); #1;
        req_valid = 1'b0;
        c2 = -1;
        for (int t = 0; t < 10 && c2 < 0; t++) begin
            @(negedge clk);
            if (rsp_valid) c2 = cyc;
        end
        chk("b2b_spacing", c2 - c1, 32'd3);
        drain();

        // Partial load session (0..2), then a fresh session must restart at 0
        prog_en = 1'b1;
        @(posedge clk); #1;
        prog_stream(3, 8'h20);
        prog_valid = 1'b0; prog_en = 1'b0;
        @(posedge clk); #1;
        prog_en = 1'b1;
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        prog_stream(16, 8'h10);
        @(negedge clk);
        chk("prog_full_set", {31'd0, prog_full}, 32'd1);
        for (int t = 0; t < 3; t++) begin
            chk("prog_ready_low_full", {30'd0, prog_ready, req_ready}, 32'd0);
            @(negedge clk);
        end
        chk("prog_write_count", wr_addr_q.size(), 32'd16);
        for (int i = 0; i < 16 && i < wr_addr_q.size(); i++) begin
            chk("prog_wr_addr", {28'd0, wr_addr_q[i]}, i);
            chk("prog_wr_data", {24'd0, wr_data_q[i]}, 32'h10 + i);
            if (i > 0) chk("prog_wr_spacing", wr_cyc_q[i] - wr_cyc_q[i-1], 32'd2);
        end
        prog_valid = 1'b0; prog_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("prog_full_clear", {31'd0, prog_full}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) cpu_read(4'(i));
        drain();

        // Reset while in RD_DATA: no response, outputs back to reset values
        accept(1'b0, 4'h5, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_outputs", {14'd0, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_re, prog_full, req_ready},
            {14'd0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("rst_rd_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // Reset on the edge that would enter WRITE: nothing committed
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h6; req_wdata = 8'hEE;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("rst_wr_no_we", {29'd0, mem_we, mem_re, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        cpu_read(4'h6);
        drain();

        // Both ports valid with prog_en=0: CPU wins, program port starved
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h9; req_wdata = 8'h99;
        prog_valid = 1'b1; prog_data = 8'h77;
        @(negedge clk);
        chk("both_ready", {30'd0, req_ready, prog_ready}, 32'd2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_ram[9] = 8'h99;
        @(negedge clk);
        chk("both_cpu_write", {18'd0, prog_ready, mem_we, mem_addr, mem_data},
            {18'd0, 1'b0, 1'b1, 4'h9, 8'h99});
        @(negedge clk);
        chk("both_prog_ready", {31'd0, prog_ready}, 32'd0);
        @(posedge clk); #1;
        prog_valid = 1'b0;
        cpu_read(4'h9);
        cpu_read(4'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, 4, RAM address width; DATA_W, 8, RAM word width.
REQ-002 Port clk  input  1  single clock; every register updates on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous and active-high.
REQ-004 Port req_valid  input  1  CPU access request.
REQ-005 Port req_write  input  1  1 = write, 0 = read; qualified by req_valid.
REQ-006 Port req_addr  input  ADDR_W  CPU target address.
REQ-007 Port req_wdata  input  DATA_W  CPU write data.
REQ-008 Port req_ready  output  1  controller can accept a CPU request this cycle.
REQ-009 Port rsp_valid  output  1  one-cycle pulse; rsp_rdata holds read data.
REQ-010 Port rsp_rdata  output  DATA_W  last read result; holds until the next read completes.
REQ-011 Port prog_en  input  1  program-load mode select.
REQ-012 Port prog_valid  input  1  program byte present on prog_data.
REQ-013 Port prog_data  input  DATA_W  program byte.
REQ-014 Port prog_ready  output  1  controller can accept a program byte this cycle.
REQ-015 Port prog_full  output  1  all 2^ADDR_W locations have been loaded in the current load session.
REQ-016 Port mem_addr  output  ADDR_W  RAM address.
REQ-017 Port mem_we  output  1  RAM write enable.
REQ-018 Port mem_re  output  1  RAM read enable.
REQ-019 Port mem_data  inout  DATA_W  RAM data bus.

Function
REQ-020 States SHALL be IDLE, WRITE, RD_ADDR and RD_DATA; mem_* outputs SHALL be decoded from registered state and registered address/data only.
REQ-021 req_ready SHALL be high only in IDLE with prog_en=0; prog_ready SHALL be high only in IDLE with prog_en=1 and prog_full=0.
REQ-022 IDLE with req_valid&req_ready SHALL latch addr/wdata and go to WRITE if req_write=1, else to RD_ADDR.
REQ-023 IDLE with prog_valid&prog_ready SHALL latch prog_ptr/prog_data and go to WRITE; prog_ptr SHALL then increment modulo 2^ADDR_W.
REQ-024 WRITE SHALL drive mem_addr=latched addr, mem_we=1, mem_re=0 and mem_data=latched data for exactly one cycle, then go to IDLE; the RAM commits on the edge that leaves WRITE.
REQ-025 RD_ADDR SHALL drive mem_addr=latched addr with mem_we=0 and mem_re=0 for one cycle; the RAM loads its output buffer on the edge that leaves RD_ADDR.
REQ-026 RD_DATA SHALL drive mem_re=1 and mem_we=0; on the edge that leaves RD_DATA the controller SHALL capture mem_data into rsp_rdata, set rsp_valid=1 for the next cycle only, and go to IDLE.
REQ-027 Latency SHALL be as follows, where E0 is the acceptance edge: a write commits at E1 and req_ready is high again in the cycle after E1; rsp_valid is high in the cycle after E2.
REQ-028 A new request SHALL be acceptable in the same cycle that rsp_valid is high.
REQ-029 mem_data SHALL be high-impedance in every state except WRITE; mem_we&mem_re SHALL never be 1.
REQ-030 prog_ptr SHALL clear to 0 on each rising edge of prog_en; prog_full SHALL set when the write to address 2^ADDR_W-1 is accepted and SHALL clear when prog_en is low.
REQ-031 If prog_en changes mid-transaction, the transaction SHALL complete unchanged; the new mode takes effect in the next IDLE.
REQ-032 If req_valid and prog_valid are both high in IDLE, the port selected by prog_en SHALL win and the other SHALL see ready=0.
REQ-033 In IDLE, mem_addr SHALL hold its last value and mem_we and mem_re SHALL be 0.

Reset
REQ-034 On rst=1 at a clock edge the controller SHALL enter IDLE and set rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_we=0, mem_re=0, mem_data=Z, prog_ptr=0 and prog_full=0.
REQ-035 A reset mid-transaction SHALL abandon the transaction with no write commit after the reset edge and no rsp_valid pulse.

Verification
REQ-036 CPU write to addr 0x3 with data 0xA5, then read addr 0x3 -> mem_we high for 1 cycle; rsp_valid at E2+1 with rsp_rdata=0xA5.
REQ-037 Back-to-back reads of 0xA then 0xB, with the second issued in the rsp_valid cycle -> two pulses 3 cycles apart carrying the RAM contents of 0xA and 0xB.
REQ-038 prog_en=1, stream 16 bytes 0x10..0x1F with prog_valid held high -> addrs 0..15 written 2 cycles apart; prog_full=1 after the last; prog_ready=0 afterwards; readback matches.
REQ-039 rst asserted in RD_DATA and, separately, in the cycle when WRITE is entered -> no rsp_valid; memory location unchanged; all outputs at reset values.
REQ-040 req_valid and prog_valid both high with prog_en=0 -> CPU request served; prog_ready=0 throughout.
REQ-041 A bus monitor SHALL check every cycle that mem_we&mem_re=0 and that mem_data is driven only in WRITE.
